// File: rtl/lsu_access_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | Module   : lsu_access_ctrl_pkg                                     |
// | Purpose  : funct3 width codes, size masks, FSM states and decoder  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package lsu_access_ctrl_pkg;

  localparam logic [1:0] F3_SZ_BYTE = 2'b00;
  localparam logic [1:0] F3_SZ_HALF = 2'b01;
  localparam logic [1:0] F3_SZ_WORD = 2'b10;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic       err;
    logic       sign;
    logic [3:0] mask;
  } dec_t;

  function automatic dec_t decode_f3(input logic i_we, input logic [2:0] i_funct3);
    dec_t d;
    d.err  = 1'b0;
    d.sign = ~i_funct3[2];
    d.mask = MASK_BYTE;
    case (i_funct3[1:0])
      F3_SZ_BYTE: d.mask = MASK_BYTE;
      F3_SZ_HALF: d.mask = MASK_HALF;
      F3_SZ_WORD: d.mask = MASK_WORD;
      default:    d.err  = 1'b1;
    endcase
    // Unsigned stores do not exist.
    if (i_we && i_funct3[2]) d.err = 1'b1;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_access_ctrl_if.sv
// +--------------------------------------------------------------------+
// | Module   : lsu_access_ctrl_if                                      |
// | Purpose  : pipeline request/response and memory beat signal bundle |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

interface lsu_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// +--------------------------------------------------------------------+
// | Module   : lsu_lane_align                                          |
// | Purpose  : byte-lane shift for stores, extract/extend for loads    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_lane_align (
  input  logic [3:0]  i_mask,
  input  logic [1:0]  i_off,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rd_lo,
  input  logic [31:0] i_rd_hi,
  output logic        o_cross,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_wdata1,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic [31:0] w_rd32;

  assign w_be8    = {4'b0000, i_mask} << i_off;
  assign w_wd64   = {32'd0, i_wdata} << {i_off, 3'b000};
  assign o_cross  = |w_be8[7:4];
  assign o_be0    = w_be8[3:0];
  assign o_be1    = w_be8[7:4];
  assign o_wdata0 = w_wd64[31:0];
  assign o_wdata1 = w_wd64[63:32];

  // Beat 1 word supplies the upper lanes of a crossing load.
  assign w_rd32 = 32'({i_rd_hi, i_rd_lo} >> {i_off, 3'b000});

  always_comb begin
    o_rdata = w_rd32;
    if (!i_mask[1]) begin
      o_rdata = {{24{i_sign & w_rd32[7]}}, w_rd32[7:0]};
    end else if (!i_mask[2]) begin
      o_rdata = {{16{i_sign & w_rd32[15]}}, w_rd32[15:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsu_access_ctrl.sv
// +--------------------------------------------------------------------+
// | Module   : lsu_access_ctrl                                         |
// | Purpose  : load/store controller with misaligned two-beat split    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_access_ctrl
  import lsu_access_ctrl_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_access_ctrl_if.slave bus
);

  state_e      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [1:0]  r_off, w_off_nxt;
  logic        r_sign, w_sign_nxt;
  logic [3:0]  r_mask, w_mask_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_cross, w_cross_nxt;
  logic [31:0] r_r0, w_r0_nxt;

  logic        r_mem_req, w_mem_req_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [3:0]  r_mem_be, w_mem_be_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;

  dec_t        w_dec;
  logic        w_idle;
  logic        w_reject;
  logic [3:0]  w_al_mask;
  logic [1:0]  w_al_off;
  logic        w_al_sign;
  logic [31:0] w_al_wdata;
  logic [31:0] w_al_lo;
  logic        w_cross;
  logic [3:0]  w_be0, w_be1;
  logic [31:0] w_wd0, w_wd1;
  logic [31:0] w_rdata;

  assign w_dec  = decode_f3(bus.req_we, bus.req_funct3);
  assign w_idle = (r_state == ST_IDLE);

  // In IDLE the aligner works on the incoming request so beat 0 can be registered at accept.
  assign w_al_mask  = w_idle ? w_dec.mask : r_mask;
  assign w_al_off   = w_idle ? bus.req_addr[1:0] : r_off;
  assign w_al_sign  = w_idle ? w_dec.sign : r_sign;
  assign w_al_wdata = w_idle ? bus.req_wdata : r_wdata;
  assign w_al_lo    = (r_state == ST_BEAT1) ? r_r0 : bus.mem_rdata;

  lsu_lane_align u_align (
    .i_mask   (w_al_mask),
    .i_off    (w_al_off),
    .i_sign   (w_al_sign),
    .i_wdata  (w_al_wdata),
    .i_rd_lo  (w_al_lo),
    .i_rd_hi  (bus.mem_rdata),
    .o_cross  (w_cross),
    .o_be0    (w_be0),
    .o_be1    (w_be1),
    .o_wdata0 (w_wd0),
    .o_wdata1 (w_wd1),
    .o_rdata  (w_rdata)
  );

  assign w_reject = w_dec.err || (w_cross && !SPLIT_EN);

  always_comb begin
    w_state_nxt     = r_state;
    w_we_nxt        = r_we;
    w_off_nxt       = r_off;
    w_sign_nxt      = r_sign;
    w_mask_nxt      = r_mask;
    w_wdata_nxt     = r_wdata;
    w_cross_nxt     = r_cross;
    w_r0_nxt        = r_r0;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_be_nxt    = r_mem_be;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = 32'd0;
    w_rsp_err_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (w_reject) begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt     = ST_BEAT0;
            w_we_nxt        = bus.req_we;
            w_off_nxt       = bus.req_addr[1:0];
            w_sign_nxt      = w_dec.sign;
            w_mask_nxt      = w_dec.mask;
            w_wdata_nxt     = bus.req_wdata;
            w_cross_nxt     = w_cross;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = bus.req_we;
            w_mem_addr_nxt  = {bus.req_addr[31:2], 2'b00};
            w_mem_be_nxt    = w_be0;
            w_mem_wdata_nxt = w_wd0;
          end
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (bus.mem_ack) begin
          if (r_state == ST_BEAT0 && r_cross) begin
            w_state_nxt     = ST_BEAT1;
            w_r0_nxt        = bus.mem_rdata;
            w_mem_addr_nxt  = r_mem_addr + 32'd4;
            w_mem_be_nxt    = w_be1;
            w_mem_wdata_nxt = w_wd1;
          end else begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = r_we ? 32'd0 : w_rdata;
            w_mem_req_nxt   = 1'b0;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = 32'd0;
            w_mem_be_nxt    = 4'd0;
            w_mem_wdata_nxt = 32'd0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_off       <= 2'd0;
      r_sign      <= 1'b0;
      r_mask      <= 4'd0;
      r_wdata     <= 32'd0;
      r_cross     <= 1'b0;
      r_r0        <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_we        <= w_we_nxt;
      r_off       <= w_off_nxt;
      r_sign      <= w_sign_nxt;
      r_mask      <= w_mask_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cross     <= w_cross_nxt;
      r_r0        <= w_r0_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign bus.req_ready = w_idle;
  assign bus.stall     = ~w_idle & bus.req_valid;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_access_ctrl.sv
// +--------------------------------------------------------------------+
// | Module   : tb_lsu_access_ctrl                                      |
// | Purpose  : directed bench for split-enabled and split-disabled LSU |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_lsu_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ns_valid = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lsu_access_ctrl_if bus ();
  lsu_access_ctrl_if bus_ns ();

  lsu_access_ctrl #(.SPLIT_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  lsu_access_ctrl #(.SPLIT_EN(1'b0)) dut_ns (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ns)
  );

  // The split-disabled instance shares request fields and memory inputs.
  assign bus_ns.req_valid  = ns_valid;
  assign bus_ns.req_we     = bus.req_we;
  assign bus_ns.req_funct3 = bus.req_funct3;
  assign bus_ns.req_addr   = bus.req_addr;
  assign bus_ns.req_wdata  = bus.req_wdata;
  assign bus_ns.mem_ack    = bus.mem_ack;
  assign bus_ns.mem_rdata  = bus.mem_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    chk("ready_at_accept", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    step();
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 32'hFFFF_FFF3;
    bus.req_wdata  = 32'h5A5A_5A5A;
  endtask

  task automatic ack(input logic [31:0] rd);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hCAFE_F00D;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'd0;
    step();
    step();

    chk("rst_req_ready",   {31'd0, bus.req_ready}, 32'd1);
    chk("rst_mem_req",     {31'd0, bus.mem_req},   32'd0);
    chk("rst_mem_addr",    bus.mem_addr,           32'd0);
    chk("rst_mem_be",      {28'd0, bus.mem_be},    32'd0);
    chk("rst_rsp_valid",   {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_ns_ready",    {31'd0, bus_ns.req_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // LW 0x100, zero-wait ack
    issue(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    bus.req_valid = 1'b1;
    chk("lw_stall",     {31'd0, bus.stall},     32'd1);
    chk("lw_mem_req",   {31'd0, bus.mem_req},   32'd1);
    chk("lw_mem_we",    {31'd0, bus.mem_we},    32'd0);
    chk("lw_mem_addr",  bus.mem_addr,           32'h0000_0100);
    chk("lw_mem_be",    {28'd0, bus.mem_be},    32'h0000_000F);
    bus.req_valid = 1'b0;
    ack(32'hDEAD_BEEF);
    chk("lw_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("lw_rsp_rdata", bus.rsp_rdata,          32'hDEAD_BEEF);
    chk("lw_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    chk("lw_mem_req_off", {31'd0, bus.mem_req}, 32'd0);
    chk("lw_busy_ready",  {31'd0, bus.req_ready}, 32'd0);
    step();
    chk("lw_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // LB 0x102 with one wait cycle
    issue(1'b0, 3'b000, 32'h0000_0102, 32'd0);
    chk("lb_mem_be",    {28'd0, bus.mem_be},    32'h0000_0004);
    step();
    chk("lb_wait_req",  {31'd0, bus.mem_req},   32'd1);
    chk("lb_wait_addr", bus.mem_addr,           32'h0000_0100);
    chk("lb_wait_be",   {28'd0, bus.mem_be},    32'h0000_0004);
    ack(32'h0080_0000);
    chk("lb_rsp_rdata", bus.rsp_rdata,          32'hFFFF_FF80);
    step();

    // LBU 0x102
    issue(1'b0, 3'b100, 32'h0000_0102, 32'd0);
    chk("lbu_mem_be",   {28'd0, bus.mem_be},    32'h0000_0004);
    ack(32'h0080_0000);
    chk("lbu_rsp_rdata", bus.rsp_rdata,         32'h0000_0080);
    step();

    // LH 0x102, negative halfword
    issue(1'b0, 3'b001, 32'h0000_0102, 32'd0);
    chk("lh_mem_be",    {28'd0, bus.mem_be},    32'h0000_000C);
    ack(32'h8001_0000);
    chk("lh_rsp_rdata", bus.rsp_rdata,          32'hFFFF_8001);
    step();

    // SH 0x103 splits into two beats
    issue(1'b1, 3'b001, 32'h0000_0103, 32'h0000_ABCD);
    chk("sh_b0_we",     {31'd0, bus.mem_we},    32'd1);
    chk("sh_b0_addr",   bus.mem_addr,           32'h0000_0100);
    chk("sh_b0_be",     {28'd0, bus.mem_be},    32'h0000_0008);
    chk("sh_b0_wdata",  bus.mem_wdata,          32'hCD00_0000);
    ack(32'h1357_9BDF);
    chk("sh_b1_req",    {31'd0, bus.mem_req},   32'd1);
    chk("sh_b1_addr",   bus.mem_addr,           32'h0000_0104);
    chk("sh_b1_be",     {28'd0, bus.mem_be},    32'h0000_0001);
    chk("sh_b1_wdata",  bus.mem_wdata,          32'h0000_00AB);
    chk("sh_b1_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    ack(32'h2468_ACE0);
    chk("sh_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("sh_rsp_rdata", bus.rsp_rdata,          32'd0);
    chk("sh_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    chk("sh_mem_req_off", {31'd0, bus.mem_req}, 32'd0);
    step();

    // LW 0xFFFFFFFE: split with address wrap; split-disabled instance rejects
    ns_valid = 1'b1;
    issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0);
    ns_valid = 1'b0;
    chk("wrap_b0_addr", bus.mem_addr,           32'hFFFF_FFFC);
    chk("wrap_b0_be",   {28'd0, bus.mem_be},    32'h0000_000C);
    chk("ns_rsp_valid", {31'd0, bus_ns.rsp_valid}, 32'd1);
    chk("ns_rsp_err",   {31'd0, bus_ns.rsp_err},   32'd1);
    chk("ns_mem_req",   {31'd0, bus_ns.mem_req},   32'd0);
    ack(32'h3344_5566);
    chk("wrap_b1_addr", bus.mem_addr,           32'h0000_0000);
    chk("wrap_b1_be",   {28'd0, bus.mem_be},    32'h0000_0003);
    chk("ns_mem_req_b1", {31'd0, bus_ns.mem_req}, 32'd0);
    ack(32'h7788_1122);
    chk("wrap_rsp_rdata", bus.rsp_rdata,        32'h1122_3344);
    chk("wrap_rsp_err", {31'd0, bus.rsp_err},   32'd0);
    step();

    // Illegal load funct3 011
    issue(1'b0, 3'b011, 32'h0000_0100, 32'd0);
    chk("ld011_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("ld011_rsp_err",   {31'd0, bus.rsp_err},   32'd1);
    chk("ld011_rsp_rdata", bus.rsp_rdata,          32'd0);
    chk("ld011_mem_req",   {31'd0, bus.mem_req},   32'd0);
    step();

    // Illegal store funct3 100
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h0000_1234);
    chk("st100_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("st100_rsp_err",   {31'd0, bus.rsp_err},   32'd1);
    chk("st100_mem_req",   {31'd0, bus.mem_req},   32'd0);
    step();

    // Reset during BEAT1 wait
    issue(1'b0, 3'b010, 32'h0000_0101, 32'd0);
    chk("rb_b0_be",     {28'd0, bus.mem_be},    32'h0000_000E);
    ack(32'h1111_1111);
    chk("rb_b1_addr",   bus.mem_addr,           32'h0000_0104);
    chk("rb_b1_be",     {28'd0, bus.mem_be},    32'h0000_0001);
    step();
    chk("rb_b1_wait",   {31'd0, bus.mem_req},   32'd1);
    rst_n = 1'b0;
    #1;
    chk("rb_mem_req",   {31'd0, bus.mem_req},   32'd0);
    chk("rb_mem_addr",  bus.mem_addr,           32'd0);
    chk("rb_mem_be",    {28'd0, bus.mem_be},    32'd0);
    chk("rb_mem_wdata", bus.mem_wdata,          32'd0);
    chk("rb_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rb_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    issue(1'b0, 3'b010, 32'h0000_0200, 32'd0);
    chk("post_rst_addr", bus.mem_addr,          32'h0000_0200);
    ack(32'h1234_5678);
    chk("post_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("post_rst_rdata", bus.rsp_rdata,        32'h1234_5678);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_access_ctrl.md
# lsu_access_ctrl

Load/store access controller between the execute/memory stage and the data memory port. It accepts one load or store per handshake and decodes width and signedness from funct3. It drives byte-enabled word accesses to memory and splits word-crossing misaligned accesses into two beats. For loads it returns aligned, sign- or zero-extended read data, and it stalls the pipeline while an access is in flight.

## Interface
- SPLIT_EN, 1, 1: split word-crossing accesses into two beats; 0: reject them with rsp_err
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3 (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- mem_req  out  1  memory beat request, held until mem_ack
- mem_we  out  1  beat is a write
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_ack  in  1  beat complete; mem_rdata valid this cycle for reads
- mem_rdata  in  32  read word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result; 0 for stores and errors
- rsp_err  out  1  access rejected, valid with rsp_valid
- stall  out  1  ~req_ready & req_valid

## Operation
- Decode funct3 into sign and size.
  - sign = ~funct3[2].
  - funct3[1:0] 00 → byte, size mask 0001. 01 → half, 0011. 10 → word, 1111.
  - funct3[1:0] 11 → error. A store with funct3[2] = 1 is also an error.
- Byte offset is off = addr[1:0]. The access crosses a word boundary when (mask << off) has any bit in [7:4].
- Beat 0: mem_addr = {addr[31:2], 2'b00}, mem_be = (mask << off)[3:0], mem_wdata = (wdata << 8·off)[31:0].
- Beat 1 (crossing only): mem_addr = beat-0 address + 4, with 32-bit wrap (0xFFFFFFFC → 0x00000000). mem_be = (mask << off)[7:4], mem_wdata = (wdata << 8·off)[63:32].
- A beat-0-only access never has mem_be = 0.
- Load result:
  - Capture r0, and r1 if crossing.
  - Form {r1, r0} >> 8·off and take the low 8, 16 or 32 bits.
  - Replicate the top bit if sign = 1, otherwise zero-fill.
- States: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: if req_valid with a legal request that needs no rejection, latch the request and go to BEAT0. If the request is illegal, or crosses with SPLIT_EN = 0, go to RESP with the error flag set and issue no memory beat.
  - BEAT0: mem_req = 1. On mem_ack, go to BEAT1 if crossing, else RESP.
  - BEAT1: mem_req = 1. On mem_ack, go to RESP.
  - RESP: rsp_valid = 1, then IDLE.
- req_ready = 1 only in IDLE.
- Request fields are latched at accept. Changes on req_* after accept are ignored.

## Timing
- Reset values:
  - State IDLE, so req_ready = 1.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata: 0.
  - rsp_valid, rsp_rdata, rsp_err: 0.
- All mem_* and rsp_* outputs are registered. mem_* are stable while mem_req = 1 and mem_ack = 0.
- Single-beat access with zero-wait ack:
  - accept in cycle 0
  - mem_req in cycle 1
  - ack in cycle 1
  - rsp_valid in cycle 2
- Each wait cycle adds one cycle. A split access adds one beat, minimum one more cycle.
- Error path: accept in cycle 0, rsp_valid with rsp_err in cycle 1.
- mem_ack outside BEAT0/BEAT1 is ignored.
- mem_req deasserts in the cycle after the final ack. Back-to-back beats deassert mem_req for zero cycles: BEAT0 → BEAT1 keeps mem_req high and updates address, enables and data.
- Next accept is possible the cycle after rsp_valid.
- rst_n asserted at any point, including mid-beat: immediate return to reset values. Software owns a torn split store.

## Structure
- Shared package/defines, alongside rv32i-defines:
  - funct3 width codes
  - size-mask constants 0001/0011/1111
  - FSM state encodings
- Sub-module lsu_lane_align, combinational:
  - lane shift and byte enables for beat 0 and beat 1
  - 64-bit right shift and sign/zero extension for loads
- The top level holds the FSM and registers.

## Test plan
- LW 0x100, mem_rdata 0xDEADBEEF, ack in cycle 1 → one beat, be 1111, rsp_rdata 0xDEADBEEF at cycle 2.
- LB and LBU at 0x102 with mem_rdata 0x00800000 → be 0100; rsp_rdata 0xFFFFFF80 for LB and 0x00000080 for LBU.
- SH at 0x103, wdata 0x0000ABCD:
  - beat 0: addr 0x100, be 1000, wdata 0xCD000000
  - beat 1: addr 0x104, be 0001, wdata 0x000000AB
- LW at 0xFFFFFFFE, r0 = 0x3344xxxx, r1 = 0xxxxx1122 → beat 1 addr 0x00000000, rsp_rdata 0x11223344. With SPLIT_EN = 0 the same access gives rsp_err = 1 and no mem_req.
- funct3 011 (load) and 100 (store) → rsp_err at cycle 1, no mem_req.
- rst_n low during BEAT1 wait → all outputs 0 and req_ready 1 asynchronously; after release, a new LW completes normally.
